ifu_pc_ctrl: RTL
================

Name: ifu_pc_ctrl

Overview:
Parametrised program-counter unit for the instruction-fetch stage of the pipelined MIPS core. Holds the fetch PC and advances it sequentially. Also supports:
- pipeline stall;
- branch/jump redirect, including a redirect buffered while stalled;
- exception vectoring and ERET return;
- a post-reset fetch-valid gate;
- instruction address-error detection against a configurable text segment.

Parameters:
- W, 32, PC width in bits (W >= 8).
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_4180, exception handler entry address.
- TEXT_BASE, 32'h0000_3000, lowest legal instruction address (inclusive).
- TEXT_END, 32'h0000_6FFC, highest legal instruction address (inclusive).
- STEP, 4, sequential increment in bytes.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- stall_i  input  1  hold the PC this cycle (hazard stall from the decode stage).
- redirect_valid_i  input  1  branch/jump taken this cycle.
- redirect_target_i  input  W  branch/jump target.
- exc_valid_i  input  1  exception/interrupt taken; enter the handler.
- eret_valid_i  input  1  ERET executed; return to epc_i.
- epc_i  input  W  return address from CP0.
- pc_o  output  W  current fetch PC; drives the IM address.
- pc_plus_o  output  W  pc_o + STEP, wrapping mod 2^W; combinational.
- fetch_valid_o  output  1  pc_o is a real fetch; the instruction may enter the pipeline.
- adel_o  output  1  fetch address error (AdEL).
- pending_o  output  1  a redirect is buffered and waiting for the stall to release.

Behaviour:
- Reset (any edge with RESET=1):
  - pc <= RESET_PC, fetch_valid <= 0, pending <= 0, pending_target <= 0.
  - All other inputs are ignored.
  - Reset mid-stall or with a buffered redirect discards the buffered redirect.
- Startup state: while fetch_valid=0, the next non-reset edge sets fetch_valid <= 1 and holds the PC, ignoring all other inputs. The first valid fetch is therefore at RESET_PC, one cycle after RESET falls.
- Steady state (fetch_valid=1): at each non-reset edge, the first matching rule applies:
  1. exc_valid_i: pc <= EXC_VECTOR; pending <= 0. Overrides stall.
  2. eret_valid_i: pc <= epc_i; pending <= 0. Overrides stall.
  3. stall_i: pc holds. If redirect_valid_i, then pending <= 1 and pending_target <= redirect_target_i; a newer redirect overwrites an older buffered one. Without a redirect, pending is unchanged.
  4. redirect_valid_i: pc <= redirect_target_i; pending <= 0. A live redirect beats a buffered one.
  5. pending: pc <= pending_target; pending <= 0.
  6. Otherwise: pc <= pc + STEP, wrapping modulo 2^W with no flag.
- exc_valid_i and eret_valid_i asserted together: the exception wins.
- Outputs:
  - pc_o, fetch_valid_o and pending_o are taken directly from registers.
  - adel_o is combinational from pc: adel_o = fetch_valid & ((pc mod 4 != 0) | pc < TEXT_BASE | pc > TEXT_END), with unsigned compares.
  - adel_o = 0 while fetch_valid = 0.
  - The block does not self-redirect on adel_o; exception control consumes it and answers with exc_valid_i.
- Latency: every redirect, exception or ERET is visible on pc_o exactly one cycle after the edge that accepts it. A buffered redirect is visible one cycle after the first unstalled edge.
- Reset values of outputs:
  - pc_o = RESET_PC
  - pc_plus_o = RESET_PC + STEP
  - fetch_valid_o = 0
  - adel_o = 0
  - pending_o = 0

Test Plan:
- Reset startup: RESET high for 2 cycles, then low.
  -> pc_o = 0x3000 and fetch_valid_o = 0 for the cycle after reset.
  -> fetch_valid_o = 1 with pc_o = 0x3000, then 0x3004, then 0x3008 on successive edges.
- Stall plus buffered redirect: at pc = 0x3010, stall for 3 cycles with redirect_valid_i and target 0x3100 on the first stalled cycle.
  -> pc_o holds 0x3010; pending_o = 1.
  -> On release, pc_o = 0x3100 and pending_o = 0, then 0x3104.
- Redirect overwrite and live-redirect priority:
  - While stalled, redirect 0x3200 then 0x3300. -> Release gives 0x3300.
  - Repeat, but assert a live redirect 0x3400 on the release cycle. -> pc_o = 0x3400.
- Exception priority: at pc = 0x3020, apply exc_valid_i together with stall_i, redirect_valid_i (target 0x3500) and eret_valid_i.
  -> pc_o = 0x4180 and pending_o = 0.
  -> Then ERET alone with epc_i = 0x3024 gives pc_o = 0x3024.
- Address error:
  - Redirect to 0x3002. -> adel_o = 1.
  - Redirect to 0x7000. -> adel_o = 1.
  - Redirect to 0x2FFC. -> adel_o = 1.
  - Redirect to 0x6FFC. -> adel_o = 0.
  - Hold RESET. -> adel_o = 0.
- Wrap and reset mid-operation:
  - With TEXT_END overridden to 32'hFFFF_FFFC, redirect to 0xFFFF_FFFC. -> Next pc_o = 0x0000_0000 with no stall.
  - Buffer a pending redirect under stall, then assert RESET. -> pc_o = 0x3000, pending_o = 0, and the redirect is never applied.

Source files
------------

// File: rtl/ifu_pc_ctrl.sv
// Fetch-stage program counter: sequential advance, stall with buffered redirect,
// exception/ERET vectoring, post-reset fetch gate and AdEL detection.
module ifu_pc_ctrl #(
  parameter int unsigned    W          = 32,
  parameter logic [W-1:0]   RESET_PC   = W'(32'h0000_3000),
  parameter logic [W-1:0]   EXC_VECTOR = W'(32'h0000_4180),
  parameter logic [W-1:0]   TEXT_BASE  = W'(32'h0000_3000),
  parameter logic [W-1:0]   TEXT_END   = W'(32'h0000_6FFC),
  parameter int unsigned    STEP       = 4
) (
  input  logic         clk,
  input  logic         RESET,
  input  logic         stall_i,
  input  logic         redirect_valid_i,
  input  logic [W-1:0] redirect_target_i,
  input  logic         exc_valid_i,
  input  logic         eret_valid_i,
  input  logic [W-1:0] epc_i,
  output logic [W-1:0] pc_o,
  output logic [W-1:0] pc_plus_o,
  output logic         fetch_valid_o,
  output logic         adel_o,
  output logic         pending_o
);

  localparam logic [W-1:0] STEP_W = W'(STEP);

  logic [W-1:0] r_pc;
  logic [W-1:0] r_pend_tgt;
  logic         r_fetch_valid;
  logic         r_pending;
  logic [W-1:0] w_pc_plus;

  // Misaligned or outside the text segment (unsigned bounds, both inclusive).
  function automatic logic f_addr_err(input logic [W-1:0] pc);
    return (pc[1:0] != 2'b00) || (pc < TEXT_BASE) || (pc > TEXT_END);
  endfunction

  assign w_pc_plus = r_pc + STEP_W;

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_pc          <= RESET_PC;
      r_fetch_valid <= 1'b0;
      r_pending     <= 1'b0;
      r_pend_tgt    <= '0;
    end else if (!r_fetch_valid) begin
      r_fetch_valid <= 1'b1;
    end else if (exc_valid_i) begin
      r_pc      <= EXC_VECTOR;
      r_pending <= 1'b0;
    end else if (eret_valid_i) begin
      r_pc      <= epc_i;
      r_pending <= 1'b0;
    end else if (stall_i) begin
      // Newest redirect seen during the stall wins; PC itself holds.
      if (redirect_valid_i) begin
        r_pending  <= 1'b1;
        r_pend_tgt <= redirect_target_i;
      end
    end else if (redirect_valid_i) begin
      r_pc      <= redirect_target_i;
      r_pending <= 1'b0;
    end else if (r_pending) begin
      r_pc      <= r_pend_tgt;
      r_pending <= 1'b0;
    end else begin
      r_pc <= w_pc_plus;
    end
  end

  assign pc_o          = r_pc;
  assign pc_plus_o     = w_pc_plus;
  assign fetch_valid_o = r_fetch_valid;
  assign pending_o     = r_pending;
  assign adel_o        = r_fetch_valid & f_addr_err(r_pc);

endmodule
